// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding for the CPU run/halt sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one synchronous button level: one history flop.
module btn_edge (
  input  logic CLK,
  input  logic RSTN,
  input  logic btn_i,
  output logic rise_o
);

  logic btn_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) btn_q <= 1'b0;
    else       btn_q <= btn_i;
  end

  assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer: button edges -> run enable, pipeline drain with timeout, cycle counter.
// Optional single-step path enabled by defining STEP_EN.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DRAIN_MAX = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             halt_req,
  input  logic             pipe_empty,
  output logic             run_en,
  output logic             flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             halted_by_insn,
  output logic             err
);

  localparam int             DW         = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_MAX - 1);

  logic rise_start, rise_stop, rise_step;
  logic step_go, step_mode_q;
  logic timeout;

  state_e           state_q,   state_d;
  logic [DW-1:0]    drain_q,   drain_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             hbi_q,     hbi_d;
  logic             err_q,     err_d;
  logic             run_en_q,  run_en_d;
  logic             flush_q,   flush_d;

  btn_edge u_start (.CLK(CLK), .RSTN(RSTN), .btn_i(start), .rise_o(rise_start));
  btn_edge u_stop  (.CLK(CLK), .RSTN(RSTN), .btn_i(stop),  .rise_o(rise_stop));
  btn_edge u_step  (.CLK(CLK), .RSTN(RSTN), .btn_i(step),  .rise_o(rise_step));

`ifdef STEP_EN
  // A step runs exactly one RUN cycle; the flag forces the following RUN cycle into DRAIN.
  assign step_go = rise_step & ~rise_start & ~rise_stop;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) step_mode_q <= 1'b0;
    else       step_mode_q <= step_go && (state_q == ST_IDLE || state_q == ST_HALTED);
  end
`else
  assign step_go     = 1'b0;
  assign step_mode_q = 1'b0;
  wire   unused_step = rise_step;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= ST_IDLE;
      drain_q  <= '0;
      cnt_q    <= '0;
      hbi_q    <= 1'b0;
      err_q    <= 1'b0;
      run_en_q <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values in parallel.
      state_q  <= state_d;
      drain_q  <= drain_d;
      cnt_q    <= cnt_d;
      hbi_q    <= hbi_d;
      err_q    <= err_d;
      run_en_q <= run_en_d;
      flush_q  <= flush_d;
    end
  end

  always_comb begin
    // NOTE: default every variable first so no path leaves one unassigned (no latch).
    state_d = state_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    hbi_d   = hbi_q;
    err_d   = err_q;
    timeout = 1'b0;

    if ((state_q == ST_RUN || state_q == ST_DRAIN) && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        // A simultaneous stop edge cancels start and step.
        if (rise_start && !rise_stop) begin
          state_d = ST_RUN;
          if (state_q == ST_IDLE) cnt_d = '0;
        end else if (step_go) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_DRAIN;
          drain_d = '0;
          hbi_d   = 1'b1;
        end else if (rise_stop || step_mode_q) begin
          state_d = ST_DRAIN;
          drain_d = '0;
          hbi_d   = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) begin
          state_d = ST_HALTED;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = ST_HALTED;
          timeout = 1'b1;
          err_d   = 1'b1;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run_en_d = (state_d == ST_RUN);
    flush_d  = timeout;
  end

  assign run_en         = run_en_q;
  assign flush          = flush_q;
  assign state          = state_q;
  assign cycle_cnt      = cnt_q;
  assign halted_by_insn = hbi_q;
  assign err            = err_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus queues hand-computed expectations, monitor checks each cycle.
module tb_cpu_run_ctrl;

  localparam int CNT_W     = 6;
  localparam int DRAIN_MAX = 16;

  localparam logic [4:0] S = 5'b10000;
  localparam logic [4:0] T = 5'b01000;
  localparam logic [4:0] P = 5'b00100;
  localparam logic [4:0] H = 5'b00010;
  localparam logic [4:0] E = 5'b00001;

  logic             CLK = 1'b0;
  logic             RSTN = 1'b0;
  logic             start = 1'b0, stop = 1'b0, step = 1'b0, halt_req = 1'b0, pipe_empty = 1'b0;
  logic             run_en, flush, halted_by_insn, err;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_cnt;

  typedef struct {
    string name;
    int    st;
    int    fl;
    int    cnt;
    int    hbi;
    int    er;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  cpu_run_ctrl #(.CNT_W(CNT_W), .DRAIN_MAX(DRAIN_MAX)) dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .stop(stop), .step(step),
    .halt_req(halt_req), .pipe_empty(pipe_empty), .run_en(run_en), .flush(flush),
    .state(state), .cycle_cnt(cycle_cnt), .halted_by_insn(halted_by_insn), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the next edge.
  task automatic cyc(input logic [4:0] in, input int st, input int fl, input int cnt,
                     input int hbi, input int er, input string nm);
    exp_t e;
    @(negedge CLK);
    {start, stop, step, halt_req, pipe_empty} = in;
    e.name = nm; e.st = st; e.fl = fl; e.cnt = cnt; e.hbi = hbi; e.er = er;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int budget = 10;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge CLK); #2;
      budget--;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".state"},  32'(state),  32'(e.st));
        check({e.name, ".run_en"}, 32'(run_en), (e.st == 1) ? 32'd1 : 32'd0);
        check({e.name, ".flush"},  32'(flush),  32'(e.fl));
        if (e.cnt >= 0) check({e.name, ".cycle_cnt"}, 32'(cycle_cnt), 32'(e.cnt));
        if (e.hbi >= 0) check({e.name, ".halted_by_insn"}, 32'(halted_by_insn), 32'(e.hbi));
        if (e.er  >= 0) check({e.name, ".err"}, 32'(err), 32'(e.er));
      end
    end
  end

  initial begin : stimulus
    #12;
    check("reset.state", 32'(state), 0);
    check("reset.run_en", 32'(run_en), 0);
    check("reset.flush", 32'(flush), 0);
    check("reset.cycle_cnt", 32'(cycle_cnt), 0);
    check("reset.hbi", 32'(halted_by_insn), 0);
    check("reset.err", 32'(err), 0);
    @(negedge CLK) RSTN = 1'b1;

    cyc(0, 0, 0, 0, 0, 0, "idle");
    cyc(S, 1, 0, 0, 0, 0, "start");
    for (int i = 1; i <= 9; i++) cyc(0, 1, 0, i, 0, 0, "run_count");
    cyc(T, 2, 0, 10, 0, 0, "stop");
    cyc(0, 2, 0, 11, 0, 0, "drain1");
    cyc(0, 2, 0, 12, 0, 0, "drain2");
    cyc(E, 3, 0, 13, 0, 0, "halted");
    repeat (3) cyc(0, 3, 0, 13, 0, 0, "halted_hold");

    cyc(S, 1, 0, 13, 0, 0, "resume");
    cyc(0, 1, 0, 14, 0, 0, "resume_run");
    cyc(0, 1, 0, 15, 0, 0, "resume_run");
    cyc(H, 2, 0, 16, 1, 0, "halt_req");
    cyc(E, 3, 0, 17, 1, 0, "halt_insn_done");

    cyc(S, 1, 0, 17, 1, 0, "resume2");
    cyc(T, 2, 0, 18, 0, 0, "stop_clears_hbi");
    for (int i = 1; i <= 15; i++) cyc(0, 2, 0, 18 + i, 0, 0, "drain_wait");
    cyc(0, 3, 1, 34, 0, 1, "drain_timeout");
    cyc(0, 3, 0, 34, 0, 1, "flush_one_cycle");

    cyc(S, 1, 0, 34, 0, 1, "err_sticky_run");
    cyc(T, 2, 0, 35, 0, 1, "err_sticky_drain");
    cyc(E, 3, 0, 36, 0, 1, "err_sticky_halt");
    cyc(S | T, 3, 0, 36, 0, 1, "start_stop_halted");
    cyc(0, 3, 0, 36, 0, 1, "release");

    cyc(S, 1, 0, 36, 0, 1, "start_held");
    cyc(S | T, 2, 0, 37, 0, 1, "start_ignored_run");
    cyc(S | E, 3, 0, 38, 0, 1, "start_held_halt");
    for (int i = 0; i < 48; i++) cyc(S, 3, 0, 38, 0, 1, "no_restart");
    cyc(0, 3, 0, 38, 0, 1, "release2");

`ifdef STEP_EN
    cyc(P, 1, 0, 38, 0, 1, "step_run");
    cyc(0, 2, 0, 39, 0, 1, "step_drain");
    cyc(E, 3, 0, 40, 0, 1, "step_halt");
    cyc(0, 3, 0, 40, 0, 1, "step_hold");
`else
    cyc(P, 3, 0, 38, 0, 1, "step_ignored");
    cyc(0, 3, 0, 38, 0, 1, "step_ignored_hold");
`endif
    wait_drain();

    @(negedge CLK) RSTN = 1'b0;
    #1;
    check("reset2.err", 32'(err), 0);
    check("reset2.state", 32'(state), 0);
    check("reset2.cycle_cnt", 32'(cycle_cnt), 0);
    @(negedge CLK) RSTN = 1'b1;

    cyc(S | T, 0, 0, 0, 0, 0, "start_stop_idle");
    cyc(0, 0, 0, 0, 0, 0, "idle_release");
    cyc(T, 0, 0, 0, 0, 0, "stop_in_idle");
    cyc(0, 0, 0, 0, 0, 0, "idle_release2");
    cyc(S, 1, 0, 0, 0, 0, "start_after_reset");
    cyc(T | H, 2, 0, 1, 1, 0, "stop_and_halt");
    cyc(E, 3, 0, 2, 1, 0, "stop_and_halt_done");
    cyc(S, 1, 0, 2, 1, 0, "resume3");
    cyc(T, 2, 0, 3, 0, 0, "drain_before_reset");
    cyc(0, 2, 0, 4, 0, 0, "drain_before_reset");
    wait_drain();

    #1 RSTN = 1'b0;
    #1;
    check("mid_drain_reset.state", 32'(state), 0);
    check("mid_drain_reset.flush", 32'(flush), 0);
    check("mid_drain_reset.run_en", 32'(run_en), 0);
    check("mid_drain_reset.cycle_cnt", 32'(cycle_cnt), 0);
    @(posedge CLK); #1;
    check("mid_drain_reset.flush_held", 32'(flush), 0);
    @(negedge CLK) RSTN = 1'b1;

    cyc(S, 1, 0, 0, 0, 0, "sat_start");
    for (int i = 1; i <= 70; i++) cyc(0, 1, 0, (i > 63) ? 63 : i, 0, 0, "sat_count");
    cyc(T, 2, 0, 63, 0, 0, "sat_stop");
    cyc(E, 3, 0, 63, 0, 0, "sat_halt");
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
